// File: rtl/apb_cfg_seq.sv
// apb_cfg_seq: APB requester that replays a fixed table of register writes,
// optionally reading each one back and comparing, and reports completion and
// the first failing entry. Intended to load pad drive/slew/pull settings from
// the boot controller without CPU involvement.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | bus idle, waiting for start; done/err flags hold
// S_WR_SETUP  | write setup phase for entry idx (psel=1, penable=0)
// S_WR_ACCESS | write access phase, waiting for pready or timeout
// S_RD_SETUP  | read-back setup phase for entry idx
// S_RD_ACCESS | read-back access phase, compare prdata on pready
// S_FINISH    | one bus-idle cycle before done is raised
module apb_cfg_seq #(
  parameter int N_ENTRIES = 8,
  parameter bit VERIFY    = 1'b1,
  parameter int TIMEOUT   = 15,
  parameter int IDX_W     = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_ENTRIES*20-1:0] tbl_addr,
  input  logic [N_ENTRIES*32-1:0] tbl_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [1:0]              err_code,
  output logic [IDX_W-1:0]        err_index,
  output logic                    apbm_psel,
  output logic                    apbm_penable,
  output logic                    apbm_pwrite,
  output logic [19:0]             apbm_paddr,
  output logic [31:0]             apbm_pwdata,
  input  logic [31:0]             apbm_prdata,
  input  logic                    apbm_pready,
  input  logic                    apbm_pslverr
);

  // Counter holds the number of ACCESS cycles already spent without pready,
  // so it never needs to exceed TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ENTRIES - 1);

  localparam logic [1:0] CODE_SLVERR  = 2'd1;
  localparam logic [1:0] CODE_MISMATCH = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SETUP,
    S_WR_ACCESS,
    S_RD_SETUP,
    S_RD_ACCESS,
    S_FINISH
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [1:0]        err_code_q;
  logic [IDX_W-1:0]  err_index_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [19:0]       paddr_q;
  logic [31:0]       pwdata_q;

  logic [IDX_W-1:0]  idx_d;
  logic [IDX_W-1:0]  sel_idx;
  logic [19:0]       sel_addr;
  logic [31:0]       sel_data;
  logic [31:0]       cur_data;
  logic              xfer_ok;
  logic              xfer_fail;
  logic [1:0]        fail_code;

  // Table lookup: sel_* is the entry the next write setup will load (entry 0
  // from idle, otherwise idx+1); cur_data is the read-back reference.
  always_comb begin
    idx_d    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    sel_idx  = (state_q == S_IDLE) ? '0 : idx_d;
    sel_addr = tbl_addr[int'(sel_idx)*20 +: 20];
    sel_data = tbl_data[int'(sel_idx)*32 +: 32];
    cur_data = tbl_data[int'(idx_q)*32 +: 32];
  end

  // Decode the outcome of the current ACCESS cycle; pslverr takes priority
  // over a data mismatch, and neither is looked at without pready.
  always_comb begin
    xfer_ok   = 1'b0;
    xfer_fail = 1'b0;
    fail_code = 2'd0;
    if (state_q == S_WR_ACCESS || state_q == S_RD_ACCESS) begin
      if (apbm_pready) begin
        if (apbm_pslverr) begin
          xfer_fail = 1'b1;
          fail_code = CODE_SLVERR;
        end else if (state_q == S_RD_ACCESS && apbm_prdata != cur_data) begin
          xfer_fail = 1'b1;
          fail_code = CODE_MISMATCH;
        end else begin
          xfer_ok = 1'b1;
        end
      end else if (cnt_q == CNT_LAST) begin
        xfer_fail = 1'b1;
        fail_code = CODE_TIMEOUT;
      end
    end
  end

  // Sequencer FSM with registered status and APB outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
      err_index_q <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
            err_index_q <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b1;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b1;
            paddr_q     <= sel_addr;
            pwdata_q    <= sel_data;
            state_q     <= S_WR_SETUP;
          end
        end
        S_WR_SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= S_WR_ACCESS;
        end
        S_RD_SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= S_RD_ACCESS;
        end
        S_WR_ACCESS, S_RD_ACCESS: begin
          if (xfer_fail) begin
            err_q       <= 1'b1;
            err_code_q  <= fail_code;
            err_index_q <= idx_q;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            state_q     <= S_FINISH;
          end else if (xfer_ok) begin
            if (state_q == S_WR_ACCESS && VERIFY) begin
              // Read back the same address; paddr is already in place.
              penable_q <= 1'b0;
              pwrite_q  <= 1'b0;
              pwdata_q  <= '0;
              state_q   <= S_RD_SETUP;
            end else if (idx_q == IDX_LAST) begin
              psel_q    <= 1'b0;
              penable_q <= 1'b0;
              pwrite_q  <= 1'b0;
              paddr_q   <= '0;
              pwdata_q  <= '0;
              state_q   <= S_FINISH;
            end else begin
              idx_q     <= idx_d;
              penable_q <= 1'b0;
              pwrite_q  <= 1'b1;
              paddr_q   <= sel_addr;
              pwdata_q  <= sel_data;
              state_q   <= S_WR_SETUP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_code     = err_code_q;
  assign err_index    = err_index_q;
  assign apbm_psel    = psel_q;
  assign apbm_penable = penable_q;
  assign apbm_pwrite  = pwrite_q;
  assign apbm_paddr   = paddr_q;
  assign apbm_pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_cfg_seq.sv
// Bench for apb_cfg_seq: a two-entry table replayed into a behavioural APB
// completer whose wait states, error injection and read-back corruption are
// selected per vector. Completed transfers are checked against a queue of
// expected transfers built before each start.
module tb_apb_cfg_seq;

  localparam int N       = 2;
  localparam int IDX_W   = 1;
  localparam int TIMEOUT = 15;

  localparam logic [19:0] A0 = 20'h00004;
  localparam logic [19:0] A1 = 20'h00008;
  localparam logic [31:0] D0 = 32'h0000_0003;
  localparam logic [31:0] D1 = 32'h0000_0001;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [N*20-1:0]   tbl_addr;
  logic [N*32-1:0]   tbl_data;
  logic              busy, done, err;
  logic [1:0]        err_code;
  logic [IDX_W-1:0]  err_index;
  logic              psel, penable, pwrite;
  logic [19:0]       paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  assign tbl_addr = {A1, A0};
  assign tbl_data = {D1, D0};

  apb_cfg_seq #(
    .N_ENTRIES(N),
    .VERIFY(1'b1),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .tbl_addr(tbl_addr),
    .tbl_data(tbl_data),
    .busy(busy),
    .done(done),
    .err(err),
    .err_code(err_code),
    .err_index(err_index),
    .apbm_psel(psel),
    .apbm_penable(penable),
    .apbm_pwrite(pwrite),
    .apbm_paddr(paddr),
    .apbm_pwdata(pwdata),
    .apbm_prdata(prdata),
    .apbm_pready(pready),
    .apbm_pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [19:0] addr;
    logic [31:0] data;
  } xfer_t;

  typedef struct {
    int waits;      // wait states per access
    int slv_entry;  // entry that answers with pslverr (-1 none)
    bit slv_rd;     // pslverr on the read-back instead of the write
    int bad_entry;  // entry whose read-back returns 0 (-1 none)
    bit hang;       // completer never raises pready
    int poke;       // cycle offset to pulse start while busy (0 none)
    int exp_done;
    bit exp_err;
    int exp_code;
    int exp_idx;
  } vec_t;

  xfer_t       sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_setup = 0;
  int          n_acc = 0;
  int          n_unstable = 0;
  int          wcnt = 0;
  logic [52:0] snap = '0;
  logic [31:0] mem [2];

  int m_waits = 0;
  int m_slv_entry = -1;
  bit m_slv_rd = 1'b0;
  int m_bad_entry = -1;
  bit m_hang = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural completer and bus monitor, evaluated away from the active edge.
  always @(negedge clk) begin : completer
    int    ent;
    xfer_t ex;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    if (psel && !penable) begin
      n_setup++;
      snap = {pwrite, paddr, pwdata};
      wcnt = 0;
    end else if (psel && penable) begin
      n_acc++;
      if ({pwrite, paddr, pwdata} !== snap) n_unstable++;
      if (!m_hang && wcnt >= m_waits) begin
        pready = 1'b1;
        ent = (paddr == A1) ? 1 : 0;
        if (ent == m_slv_entry && m_slv_rd == !pwrite) pslverr = 1'b1;
        if (!pwrite) prdata = (ent == m_bad_entry) ? 32'h0 : mem[ent];
        else if (!pslverr) mem[ent] = pwdata;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL xfer_extra: got wr=%0b addr=0x%05h data=0x%08h, want no transfer",
                   pwrite, paddr, pwdata);
        end else begin
          ex = sb_q.pop_front();
          check("xfer", {11'b0, pwrite, paddr, pwdata}, {11'b0, ex});
        end
      end else begin
        wcnt++;
      end
    end
  end

  task automatic check_idle(input string name);
    check(name, {busy, done, err, err_code, err_index, psel, penable, pwrite, paddr, pwdata}, '0);
  endtask

  task automatic run_vector(input vec_t v);
    int pushed;
    int s0, a0, u0;
    int lat;
    m_waits     = v.waits;
    m_slv_entry = v.slv_entry;
    m_slv_rd    = v.slv_rd;
    m_bad_entry = v.bad_entry;
    m_hang      = v.hang;
    pushed = 0;
    for (int i = 0; i < N; i++) begin
      if (v.hang) break;
      sb_q.push_back(xfer_t'{1'b1, (i == 0) ? A0 : A1, (i == 0) ? D0 : D1});
      pushed++;
      if (v.slv_entry == i && !v.slv_rd) break;
      sb_q.push_back(xfer_t'{1'b0, (i == 0) ? A0 : A1, 32'h0});
      pushed++;
      if ((v.slv_entry == i && v.slv_rd) || v.bad_entry == i) break;
    end
    s0 = n_setup;
    a0 = n_acc;
    u0 = n_unstable;

    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("start_clears", {done, err, err_code, err_index}, '0);
    check("busy_t1", busy, 1);
    check("setup_e0", {psel, penable, pwrite, paddr, pwdata}, {3'b101, A0, D0});

    lat = -1;
    for (int k = 2; k <= 60; k++) begin
      @(negedge clk);
      start = (k == v.poke);
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;

    check("done_cycle", lat, v.exp_done);
    check("err", err, v.exp_err);
    check("err_code", err_code, v.exp_code);
    check("err_index", err_index, v.exp_idx);
    check("busy_end", {busy, psel, penable}, 0);
    check("setups", n_setup - s0, pushed + (v.hang ? 1 : 0));
    check("addr_data_stable", n_unstable - u0, 0);
    check("xfer_missing", sb_q.size(), 0);
    if (v.hang) check("timeout_access_cycles", n_acc - a0, TIMEOUT);
    sb_q.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t vecs[8];
    //          waits slv sr bad hang poke done err code idx
    vecs[0] = '{0, -1, 1'b0, -1, 1'b0, 5, 10, 1'b0, 0, 0};  // clean, start poked mid-run
    vecs[1] = '{2, -1, 1'b0, -1, 1'b0, 0, 18, 1'b0, 0, 0};  // 2 wait states each access
    vecs[2] = '{0, -1, 1'b0,  1, 1'b0, 0, 10, 1'b1, 2, 1};  // read-back of entry 1 is 0
    vecs[3] = '{0,  0, 1'b0, -1, 1'b0, 0,  4, 1'b1, 1, 0};  // pslverr on entry 0 write
    vecs[4] = '{0, -1, 1'b0, -1, 1'b1, 0, 18, 1'b1, 3, 0};  // pready never comes
    vecs[5] = '{0, -1, 1'b0, -1, 1'b0, 9, 10, 1'b0, 0, 0};  // rerun after error, start in FINISH
    vecs[6] = '{0,  1, 1'b1, -1, 1'b0, 0, 10, 1'b1, 1, 1};  // pslverr on entry 1 read
    vecs[7] = '{1, -1, 1'b0,  0, 1'b0, 0,  8, 1'b1, 2, 0};  // 1 wait state, entry 0 mismatch

    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset_state");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vector(vecs[i]);
      @(negedge clk);
    end

    // Reset in the middle of a write access: bus drops on the next edge.
    m_hang      = 1'b1;
    m_waits     = 0;
    m_slv_entry = -1;
    m_bad_entry = -1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_access", {psel, penable, pwrite, paddr}, {3'b111, A0});
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle("rst_mid_access");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("idle_after_rst");
    sb_q.delete();

    run_vector(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
